rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/a3/wd3) between NREQ writeback requesters, e.g. ALU writeback and load-unit writeback.
- Each requester uses a valid/ready handshake; round-robin arbitration picks one requester per cycle.
- The winning write is registered for one cycle and then drives the write port.
- The same registered write is exported as a bypass, so decode can forward a value that is being written this cycle.

---
 rtl/rv_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared core types and constants for the register-file writeback path.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  // One writeback request: destination register plus write data.
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [PW-1:0]   gnt_idx,
  output logic [NREQ-1:0] gnt_onehot
);

  logic [PW-1:0] idx;

  // Scan from the lowest priority offset down so the highest-priority hit is written last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt_valid  = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    idx        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
    if (gnt_valid) gnt_onehot[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port among NREQ writeback requesters.
// One round-robin winner per cycle is registered, then drives the write port
// and the decode bypass for exactly the cycle it is written.
module rf_wb_arbiter
  import rv_pkg::*;
#(
  parameter  int XLEN = rv_pkg::XLEN,
  parameter  int AW   = rv_pkg::AW,
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 byp_valid,
  output logic [AW-1:0]        byp_addr,
  output logic [XLEN-1:0]      byp_data,
  output logic                 conflict
);

  logic            out_valid;
  logic [AW-1:0]   out_addr;
  logic [XLEN-1:0] out_data;
  logic [PW-1:0]   rr_ptr;

  logic            gnt_valid;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_onehot;
  logic            can_accept;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  // The output stage can take a new write when empty or when it drains this cycle.
  assign can_accept = !out_valid || !hold;
  assign accept     = gnt_valid && can_accept;
  assign req_ready  = (rst || !can_accept) ? '0 : gnt_onehot;

  // Steer the winning requester's address and data toward the output stage.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Flag two valid requesters aiming at the same nonzero register.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (req_valid[i] && req_valid[j] &&
            req_addr[i*AW +: AW] == req_addr[j*AW +: AW] &&
            req_addr[i*AW +: AW] != '0)
          conflict = 1'b1;
      end
    end
  end

  // Output stage and round-robin pointer; x0 writes are consumed but never stored as valid.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= (sel_addr != '0);
      out_addr  <= sel_addr;
      out_data  <= sel_data;
      rr_ptr    <= PW'(rr_next(int'(gnt_idx), NREQ));
    end else if (out_valid && !hold) begin
      out_valid <= 1'b0;
    end
  end

  assign rf_we     = out_valid && !hold;
  assign rf_waddr  = out_addr;
  assign rf_wdata  = out_data;
  assign byp_valid = rf_we;
  assign byp_addr  = out_addr;
  assign byp_data  = out_data;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a negedge monitor predicts grants and
// queues expected writes; per-feature tasks check the scenario specifics.
module tb_rf_wb_arbiter;
  import rv_pkg::*;

  localparam int NREQ = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 hold;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 byp_valid;
  logic [AW-1:0]        byp_addr;
  logic [XLEN-1:0]      byp_data;
  logic                 conflict;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .byp_valid (byp_valid),
    .byp_addr  (byp_addr),
    .byp_data  (byp_data),
    .conflict  (conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state and scoreboard
  logic            m_ov;
  int              m_ptr;
  logic            m_can;
  logic            m_gv;
  int              m_g;
  int              mi;
  logic [NREQ-1:0] m_ready;
  logic            m_conf;
  wb_req_t         m_e;
  wb_req_t         sb[$];
  logic [XLEN-1:0] shadow[32];

  // Monitor: inputs are stable from posedge+1 to the next posedge, so sample at negedge.
  always @(negedge clk) begin
    if (rst) begin
      m_ov  = 1'b0;
      m_ptr = 0;
      sb.delete();
      checks++;
      if (rf_we !== 1'b0) begin
        errors++; $display("FAIL mon_rst_we: got %b expected 0", rf_we);
      end
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL mon_rst_ready: got %b expected 00", req_ready);
      end
    end else begin
      m_can = !m_ov || !hold;
      m_gv  = 1'b0;
      m_g   = 0;
      for (int k = 0; k < NREQ; k++) begin
        mi = (m_ptr + k) % NREQ;
        if (!m_gv && req_valid[mi]) begin
          m_gv = 1'b1;
          m_g  = mi;
        end
      end
      m_ready = '0;
      if (m_gv && m_can) m_ready[m_g] = 1'b1;
      m_conf = 1'b0;
      for (int i = 0; i < NREQ; i++)
        for (int j = i + 1; j < NREQ; j++)
          if (req_valid[i] && req_valid[j] && req_addr[i*AW +: AW] == req_addr[j*AW +: AW]
              && req_addr[i*AW +: AW] != '0)
            m_conf = 1'b1;

      checks++;
      if (req_ready !== m_ready) begin
        errors++; $display("FAIL mon_ready: got %b expected %b", req_ready, m_ready);
      end
      checks++;
      if (rf_we !== (m_ov && !hold)) begin
        errors++; $display("FAIL mon_we: got %b expected %b", rf_we, m_ov && !hold);
      end
      checks++;
      if (conflict !== m_conf) begin
        errors++; $display("FAIL mon_conflict: got %b expected %b", conflict, m_conf);
      end
      if (rf_we === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_unexpected: got write x%0d=%h expected none", rf_waddr, rf_wdata);
        end else begin
          m_e = sb.pop_front();
          if (rf_waddr !== m_e.addr || rf_wdata !== m_e.data) begin
            errors++;
            $display("FAIL sb_write: got x%0d=%h expected x%0d=%h", rf_waddr, rf_wdata, m_e.addr, m_e.data);
          end
        end
        checks++;
        if (byp_valid !== 1'b1 || byp_addr !== rf_waddr || byp_data !== rf_wdata) begin
          errors++;
          $display("FAIL bypass: got %b x%0d=%h expected 1 x%0d=%h", byp_valid, byp_addr, byp_data, rf_waddr, rf_wdata);
        end
        shadow[rf_waddr] = rf_wdata;
      end
      // Advance the model to the state after the coming edge.
      if (m_gv && m_can) begin
        m_e.addr = req_addr[m_g*AW +: AW];
        m_e.data = req_data[m_g*XLEN +: XLEN];
        if (m_e.addr != '0) begin
          sb.push_back(m_e);
          m_ov = 1'b1;
        end else begin
          m_ov = 1'b0;
        end
        m_ptr = (m_g + 1) % NREQ;
      end else if (m_ov && !hold) begin
        m_ov = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold = 1'b0;
    set_req(0, 1'b1, 5'd1, 32'h100);
    set_req(1, 1'b1, 5'd2, 32'h200);
    tick();
    tick();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_out: got x%0d=%h expected x0=0", rf_waddr, rf_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", req_ready); end
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h100) begin
      errors++; $display("FAIL reset_first_write: got %b x%0d=%h expected 1 x1=100", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL reset_ptr_adv: got %b expected 10", req_ready); end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_alternate();
    logic [AW-1:0]   ea;
    logic [XLEN-1:0] ed;
    do_reset();
    set_req(0, 1'b1, 5'd5, 32'h11);
    set_req(1, 1'b1, 5'd6, 32'h22);
    tick();
    for (int n = 0; n < 4; n++) begin
      ea = (n % 2 == 0) ? 5'd5 : 5'd6;
      ed = (n % 2 == 0) ? 32'h11 : 32'h22;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== ea || rf_wdata !== ed) begin
        errors++; $display("FAIL alt_seq%0d: got %b x%0d=%h expected 1 x%0d=%h", n, rf_we, rf_waddr, rf_wdata, ea, ed);
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready: got %b expected 10", req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (rf_we !== 1'b0 || byp_valid !== 1'b0) begin
        errors++; $display("FAIL x0_no_write%0d: got we=%b byp=%b expected 0 0", n, rf_we, byp_valid);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'h1234);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 5'd8, 32'h88);
    hold = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (rf_we !== 1'b0 || req_ready !== 2'b00) begin
        errors++; $display("FAIL hold_cycle%0d: got we=%b ready=%b expected 0 00", n, rf_we, req_ready);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234) begin
      errors++; $display("FAIL hold_release: got %b x%0d=%h expected 1 x7=1234", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_refill: got %b expected 10", req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h88) begin
      errors++; $display("FAIL hold_next: got %b x%0d=%h expected 1 x8=88", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_drained: got %b expected 0", rf_we); end
  endtask

  task automatic test_conflict();
    do_reset();
    shadow[9] = 32'h0;
    set_req(0, 1'b1, 5'd9, 32'hA);
    set_req(1, 1'b1, 5'd9, 32'hB);
    #1;
    checks++;
    if (conflict !== 1'b1) begin errors++; $display("FAIL conflict_flag: got %b expected 1", conflict); end
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (conflict !== 1'b0 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA) begin
      errors++; $display("FAIL conflict_first: got c=%b x%0d=%h expected 0 x9=a", conflict, rf_waddr, rf_wdata);
    end
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'hB) begin
      errors++; $display("FAIL conflict_second: got %b %h expected 1 b", rf_we, rf_wdata);
    end
    tick();
    tick();
    checks++;
    if (shadow[9] !== 32'hB) begin errors++; $display("FAIL conflict_last_wins: got %h expected b", shadow[9]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 5'd3, 32'h77);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    checks++;
    if (shadow[3] !== 32'h77) begin errors++; $display("FAIL rmid_preload: got %h expected 77", shadow[3]); end
    set_req(0, 1'b1, 5'd3, 32'h55);
    tick();
    rst = 1'b1;
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b expected 0", rf_we); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (shadow[3] !== 32'h77) begin errors++; $display("FAIL rmid_kept: got %h expected 77", shadow[3]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst = 1'b1;
    hold = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    test_reset();
    test_alternate();
    test_x0();
    test_hold();
    test_conflict();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
